// File: rtl/nco_i2s_tx.sv
`default_nettype none
// ============================================================================
// nco_i2s_tx : buffers NCO samples in a small FIFO and sends each as a stereo I2S frame.
// Optional macro NCO_I2S_TX_ATTEN_EN adds a 2-bit arithmetic-shift attenuator.  Rev 1.0
// ============================================================================
module nco_i2s_tx #(
  parameter int DATA_W     = 14,
  parameter int SLOT_W     = 16,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
`ifdef NCO_I2S_TX_ATTEN_EN
  input  logic [1:0]        atten,
`endif
  output logic              in_ready,
  output logic              aud_bclk,
  output logic              aud_daclrck,
  output logic              aud_dacdat,
  output logic              overflow,
  output logic              underflow
);

  localparam int C_DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int C_BIT_W = $clog2(2 * SLOT_W);
  localparam int C_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(BCLK_DIV - 1);
  localparam logic [C_BIT_W-1:0] C_BIT_LAST = C_BIT_W'(2 * SLOT_W - 1);
  localparam logic [C_BIT_W-1:0] C_SLOT     = C_BIT_W'(SLOT_W);

  logic [C_DIV_W-1:0] r_div_cnt;
  logic [C_BIT_W-1:0] r_bit_cnt;
  logic [C_PTR_W:0]   r_wr_ptr;
  logic [C_PTR_W:0]   r_rd_ptr;
  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]  r_sample;

  logic               w_div_wrap;
  logic               w_fall;
  logic               w_frame_start;
  logic [C_BIT_W-1:0] w_bit_nxt;
  logic [C_BIT_W-1:0] w_pos;
  logic [C_BIT_W-1:0] w_idx;
  logic [SLOT_W-1:0]  w_word;
  logic [SLOT_W-1:0]  w_word_sh;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [DATA_W-1:0]  w_head;
  logic [DATA_W-1:0]  w_head_adj;

  // ---------------------------------------------------------------- divider
  assign w_div_wrap = (r_div_cnt == C_DIV_LAST);
  assign w_fall     = w_div_wrap & aud_bclk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      aud_bclk  <= 1'b0;
    end else if (w_div_wrap) begin
      r_div_cnt <= '0;
      aud_bclk  <= ~aud_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- framing
  assign w_bit_nxt     = (r_bit_cnt == C_BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
  assign w_frame_start = w_fall & (r_bit_cnt == C_BIT_LAST);
  assign w_pos         = (w_bit_nxt >= C_SLOT) ? (w_bit_nxt - C_SLOT) : w_bit_nxt;
  // Slot position 0 carries the previous word's LSB, which is bit 0 of the
  // word still held at this edge; positions 1.. walk down from the MSB.
  assign w_idx         = (w_pos == '0) ? '0 : (C_SLOT - w_pos);
  assign w_word_sh     = w_word >> w_idx;

  generate
    if (SLOT_W > DATA_W) begin : g_word_pad
      assign w_word = {r_sample, {(SLOT_W - DATA_W){1'b0}}};
    end else begin : g_word_nopad
      assign w_word = r_sample;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt   <= C_BIT_LAST;
      aud_daclrck <= 1'b0;
      aud_dacdat  <= 1'b0;
    end else if (w_fall) begin
      r_bit_cnt   <= w_bit_nxt;
      aud_daclrck <= (w_bit_nxt >= C_SLOT);
      aud_dacdat  <= w_word_sh[0];
    end
  end

  // ---------------------------------------------------------------- FIFO
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[C_PTR_W] != r_rd_ptr[C_PTR_W]) &&
                    (r_wr_ptr[C_PTR_W-1:0] == r_rd_ptr[C_PTR_W-1:0]);
  assign w_pop    = w_frame_start & ~w_empty;
  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign w_push   = in_valid & (~w_full | w_pop);
  assign in_ready = ~w_full;
  assign w_head   = r_mem[r_rd_ptr[C_PTR_W-1:0]];

`ifdef NCO_I2S_TX_ATTEN_EN
  assign w_head_adj = $signed(w_head) >>> atten;
`else
  assign w_head_adj = w_head;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[C_PTR_W-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_sample  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_sample <= w_head_adj;
      end
      if (w_frame_start && w_empty) begin
        underflow <= 1'b1;
      end
      if (in_valid && w_full && !w_pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nco_i2s_tx.sv
`default_nettype none
// tb_nco_i2s_tx : directed scenarios plus random traffic against a
// time-based behavioural model of the I2S transmitter.
module tb_nco_i2s_tx;
  localparam int DATA_W     = 14;
  localparam int SLOT_W     = 16;
  localparam int BCLK_DIV   = 4;
  localparam int FIFO_DEPTH = 4;

  logic              clk      = 1'b0;
  logic              reset_n  = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data  = '0;
  logic              in_ready;
  logic              aud_bclk;
  logic              aud_daclrck;
  logic              aud_dacdat;
  logic              overflow;
  logic              underflow;

  int checks = 0;
  int errors = 0;

  nco_i2s_tx #(
    .DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
    .aud_dacdat(aud_dacdat), .overflow(overflow), .underflow(underflow)
  );

  initial forever #4 clk = ~clk;

  // ---------------------------------------------------------------- model
  int                cyc      = 0;
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_sample = '0;
  logic [SLOT_W-1:0] m_word   = '0;
  logic exp_bclk = 0, exp_lrck = 0, exp_dat = 0, exp_ovf = 0, exp_unf = 0, exp_rdy = 1;

  function automatic logic [SLOT_W-1:0] word_of(input logic [DATA_W-1:0] s);
    return SLOT_W'(s) << (SLOT_W - DATA_W);
  endfunction

  task automatic model_reset();
    cyc = 0; q.delete(); m_sample = '0; m_word = '0;
    exp_bclk = 0; exp_lrck = 0; exp_dat = 0; exp_ovf = 0; exp_unf = 0; exp_rdy = 1;
  endtask

  task automatic model_step();
    int k, pos, p;
    logic lsb_prev;
    bit popped, was_full;
    cyc++;
    was_full = (q.size() == FIFO_DEPTH);
    popped   = 0;
    exp_bclk = ((cyc / BCLK_DIV) % 2) == 1;
    if (cyc % (2 * BCLK_DIV) == 0) begin
      k        = cyc / (2 * BCLK_DIV);
      pos      = (k - 1) % (2 * SLOT_W);
      lsb_prev = m_word[0];
      if (pos == 0) begin
        if (q.size() > 0) begin
          m_sample = q.pop_front();
          popped   = 1;
        end else begin
          exp_unf = 1;
        end
      end
      m_word   = word_of(m_sample);
      exp_lrck = (pos >= SLOT_W);
      p        = pos % SLOT_W;
      exp_dat  = (p == 0) ? lsb_prev : m_word[SLOT_W - p];
    end
    if (in_valid) begin
      if (was_full && !popped) exp_ovf = 1;
      else q.push_back(in_data);
    end
    exp_rdy = (q.size() < FIFO_DEPTH);
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) model_reset();
    else model_step();
  end

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    check("bclk",      aud_bclk,    exp_bclk);
    check("lrck",      aud_daclrck, exp_lrck);
    check("dacdat",    aud_dacdat,  exp_dat);
    check("overflow",  overflow,    exp_ovf);
    check("underflow", underflow,   exp_unf);
    check("in_ready",  in_ready,    exp_rdy);
  end

  task automatic wait_cyc(input int t);
    int g;
    g = 0;
    while (cyc < t && g < 200000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != t) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: reached %0d required %0d", cyc, t);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic capture(input int start, output logic [SLOT_W-1:0] w);
    w = '0;
    for (int i = 0; i < SLOT_W; i++) begin
      wait_cyc(start + 2 * BCLK_DIV * i);
      w[SLOT_W-1-i] = aud_dacdat;
    end
  endtask

  task automatic run_random(input int ncyc, input int range);
    for (int c = 0; c < ncyc; c++) begin
      in_valid = ($urandom_range(0, range - 1) == 0);
      in_data  = DATA_W'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  logic [SLOT_W-1:0] w;
  logic [DATA_W-1:0] s [6];

  initial begin
    s[0] = 14'h0AAA; s[1] = 14'h0001; s[2] = 14'h2001;
    s[3] = 14'h3555; s[4] = 14'h1111; s[5] = 14'h2222;

    // Reset for 14 half-cycles, idle line.
    #56 reset_n = 1'b1;
    wait_cyc(3);   check("s1_bclk_c3", aud_bclk, 0);
    wait_cyc(4);   check("s1_bclk_c4", aud_bclk, 1); check("s1_model_bclk", exp_bclk, 1);
    wait_cyc(8);   check("s1_bclk_c8", aud_bclk, 0); check("s1_unf_c8", underflow, 1);
    check("s1_model_unf", exp_unf, 1);
    wait_cyc(135); check("s1_lrck_c135", aud_daclrck, 0);
    wait_cyc(136); check("s1_lrck_c136", aud_daclrck, 1);

    // Positive full-scale sample.
    do_reset();
    wait_cyc(1); in_valid = 1; in_data = 14'h1FFF; @(negedge clk); in_valid = 0;
    capture(16, w);  check("s2_left", w, 16'h7FFC);
    check("s2_unf_mid", underflow, 0);
    capture(144, w); check("s2_right", w, 16'h7FFC);

    // Negative full-scale sample, then an empty frame repeats it.
    do_reset();
    wait_cyc(1); in_valid = 1; in_data = 14'h2000; @(negedge clk); in_valid = 0;
    capture(16, w);  check("s3_left", w, 16'h8000);
    check("s3_unf_mid", underflow, 0);
    capture(144, w); check("s3_right", w, 16'h8000);
    check("s3_unf_repeat", underflow, 1);
    capture(272, w); check("s3_left_repeat", w, 16'h8000);

    // Six back-to-back pushes into an empty FIFO.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_data = s[i];
      @(negedge clk);
      if (i == 2) check("s4_rdy_after3", in_ready, 1);
      if (i == 3) begin check("s4_rdy_after4", in_ready, 0); check("s4_ovf_after4", overflow, 0); end
      if (i == 4) check("s4_ovf_after5", overflow, 1);
    end
    in_valid = 0;
    wait_cyc(8);    check("s4_rdy_pop", in_ready, 1);
    capture(16, w);  check("s4_frame1", w, 16'h2AA8);
    capture(784, w); check("s4_frame4", w, 16'hD554);
    wait_cyc(1031); check("s4_unf_pre", underflow, 0);
    wait_cyc(1032); check("s4_unf_post", underflow, 1);
    capture(1040, w); check("s4_frame5", w, 16'hD554);

    // Full FIFO with a push on the pop clock.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = s[i]; @(negedge clk);
    end
    in_valid = 0;
    wait_cyc(7); check("s5_rdy_full", in_ready, 0);
    in_valid = 1; in_data = 14'h0777; @(negedge clk);
    check("s5_ovf", overflow, 0); check("s5_rdy", in_ready, 0);
    @(negedge clk); in_valid = 0;
    check("s5_ovf_later", overflow, 1);

    // Asynchronous reset in the right slot.
    wait_cyc(204); check("s6_lrck", aud_daclrck, 1); check("s6_bclk", aud_bclk, 1);
    #1 reset_n = 1'b0;
    #1;
    check("s6_rst_bclk", aud_bclk, 0); check("s6_rst_lrck", aud_daclrck, 0);
    check("s6_rst_dat", aud_dacdat, 0); check("s6_rst_ovf", overflow, 0);
    check("s6_rst_unf", underflow, 0);  check("s6_rst_rdy", in_ready, 1);
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    wait_cyc(4); check("s6_bclk_c4", aud_bclk, 1);
    wait_cyc(8); check("s6_bclk_c8", aud_bclk, 0); check("s6_unf_c8", underflow, 1);

    // Random traffic at several rates.
    do_reset();
    run_random(3000, 300);
    run_random(2000, 200);
    do_reset();
    run_random(2500, 120);
    run_random(300, 3);
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nco_i2s_tx.md
Name: nco_i2s_tx

Overview:
- Downstream consumer of the NCO sine output.
- Accepts 14-bit two's-complement samples qualified by the NCO's out_valid strobe and buffers them in a small FIFO.
- Serialises each sample as a stereo I2S frame (same sample on left and right) for the DE1 WM8731 audio DAC.
- Generates the codec bit clock and LR clock locally from the system clock.

Parameters:
- DATA_W, 14: input sample width; signed two's complement.
- SLOT_W, 16: bits per channel slot on the I2S line. Must be >= DATA_W.
- BCLK_DIV, 4: clk cycles per BCLK half-period. BCLK period = 2*BCLK_DIV clk. Must be >= 1.
- FIFO_DEPTH, 4: sample FIFO entries. Must be a power of 2 and >= 2.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: sample strobe (NCO out_valid).
- in_data, input, DATA_W: signed sample (NCO fsin_o).
- in_ready, output, 1: FIFO not full. Informational only; the NCO does not stall.
- aud_bclk, output, 1: I2S bit clock.
- aud_daclrck, output, 1: I2S word select; 0 = left, 1 = right.
- aud_dacdat, output, 1: I2S serial data, MSB first.
- overflow, output, 1: sticky; a sample was dropped because the FIFO was full.
- underflow, output, 1: sticky; a frame started with the FIFO empty.

Behaviour:
- Reset (async, immediate):
  - aud_bclk = 0, aud_daclrck = 0, aud_dacdat = 0.
  - overflow = 0, underflow = 0, in_ready = 1.
  - FIFO empty; last-sample register = 0; div_cnt = 0; bit_cnt = 2*SLOT_W-1.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1. On wrap, aud_bclk toggles.
  - A wrap with aud_bclk = 1 is a fall event; codec samples on BCLK rise.
  - After reset release: first rise after BCLK_DIV clk cycles, first fall after 2*BCLK_DIV.
- Fall event sequence:
  - bit_cnt increments modulo 2*SLOT_W.
  - aud_daclrck <= (new bit_cnt >= SLOT_W).
  - aud_dacdat updates as specified in the I2S framing bullets below.
- Frame start is the fall event where bit_cnt wraps to 0:
  - FIFO not empty: pop the head into the word register.
  - FIFO empty: keep the last sample in the word register and set underflow.
- Word formation:
  - word = {sample, (SLOT_W-DATA_W) zero bits}, i.e. left-justified with the sign preserved.
  - Examples: 14'h1FFF -> 16'h7FFC; 14'h2000 -> 16'h8000.
- I2S framing (slot position p = bit_cnt mod SLOT_W):
  - p = 0: dacdat = LSB of the previous channel's word.
  - p >= 1: dacdat = word[SLOT_W-p].
  - The MSB therefore appears one BCLK after each LRCK edge. Left and right slots carry the same word.
- FIFO write:
  - in_valid=1 and not full: store in_data.
  - in_valid=1 and full: drop the sample and set overflow.
  - in_valid is sampled every clk, independent of the divider.
- Simultaneous events:
  - Pop and write in the same clk while full: the write is accepted (space frees that cycle); no overflow.
  - Pop and write in the same clk while empty: no bypass. Underflow is set, the last sample repeats, and the write is stored for the next frame.
- Frame rate: fs = f_clk / (2*BCLK_DIV*2*SLOT_W). With defaults at 125 MHz this is ~488 kHz.
- The NCO sample rate must not exceed fs on average; excess samples are dropped per the overflow rule.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: NCO_I2S_TX_ATTEN_EN.
- Defined:
  - Adds input port atten, 2 bits, after in_data.
  - At frame-start pop, the popped sample is arithmetic-right-shifted by atten (0..3) before word formation.
  - The repeated sample on underflow is not shifted again.
- Undefined: no atten port and no shift.

Test Plan (defaults, 8 ns clk):
- Reset, hold reset_n=0 for 14 half-cycles, then release, no input -> aud_bclk first rises at clk 4 and falls at clk 8. aud_daclrck low for 16 BCLKs, then high for 16. aud_dacdat all 0. Underflow set at the first frame start.
- Push one 14'h1FFF before the first frame start -> left slot bits p1..p16 = 0,1x13,0,0 (16'h7FFC); right slot identical. Underflow stays 0 for that frame.
- Push one 14'h2000 -> both slots serialise 16'h8000 (1 followed by 15 zeros). The next empty frame repeats 16'h8000 and underflow = 1.
- Push 6 samples on consecutive clks (1..6) between frame starts with the FIFO empty -> in_ready falls after the 4th, overflow = 1. The next four frames carry samples 1,2,3,4; the 5th frame repeats 4 and sets underflow.
- FIFO full with a push landing on the frame-start pop clk -> push accepted, overflow stays 0, in_ready stays 0.
- Assert reset_n=0 mid right slot -> all outputs 0 within the same time step without waiting for clk. After release, timing restarts as in the first scenario and the FIFO is empty.
